// File: rtl/joy_conditioner_if.sv
// Player-word, autofire-select and debounced-output bundle for joy_conditioner.
// Latency: none (signal grouping only).
// Backpressure: none; all signals are level or single-cycle strobes.
interface joy_conditioner_if;
    logic [7:0]  joy1_i;
    logic [7:0]  joy2_i;
    logic [1:0]  autofire_sel;
    logic [7:0]  joy1_db;
    logic [7:0]  joy2_db;
    logic [15:0] joy_press;
    logic [15:0] joy_release;
    logic        tick;

    modport master (
        output joy1_i, joy2_i, autofire_sel,
        input  joy1_db, joy2_db, joy_press, joy_release, tick
    );

    modport slave (
        input  joy1_i, joy2_i, autofire_sel,
        output joy1_db, joy2_db, joy_press, joy_release, tick
    );
endinterface

// File: rtl/joy_conditioner.sv
// Resync + per-button tick-based debounce with press/release pulses; JOY_AUTOFIRE_EN adds fire1 autofire.
// Latency: 2 sync cycles + wait to next tick + (DEBOUNCE_TICKS-1) ticks + 1 cycle.
// Backpressure: none; pulses are one-cycle strobes the consumer must catch.
module joy_conditioner #(
    parameter int TICK_DIV       = 1389,
    parameter int DEBOUNCE_TICKS = 16,
    parameter int AUTOFIRE_TICKS = 50
) (
    input  logic              clk,
    input  logic              clock_locked,
    joy_conditioner_if.slave  bus
);

    logic [15:0] sync1;
    logic [15:0] sync2;
    logic [15:0] raw;
    logic [15:0] stable;
    logic [15:0] accept;
    logic [15:0] press_q;
    logic [15:0] release_q;
    logic [4:0]  cnt [16];
    logic [15:0] tick_cnt;
    logic        tick;
    logic [1:0]  fire_out;

    assign raw  = ~sync2;
    assign tick = (tick_cnt == 16'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge clock_locked) begin
        if (!clock_locked) begin
            sync1    <= '1;
            sync2    <= '1;
            tick_cnt <= '0;
        end else begin
            sync1    <= {bus.joy2_i, bus.joy1_i};
            sync2    <= sync1;
            tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < 16; i++) begin
            accept[i] = tick && (raw[i] != stable[i]) && (cnt[i] == 5'(DEBOUNCE_TICKS - 1));
        end
    end

    // Pulses are rewritten every cycle, so each one lasts exactly one clk.
    always_ff @(posedge clk or negedge clock_locked) begin
        if (!clock_locked) begin
            stable    <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable    <= stable ^ accept;
            press_q   <= accept & raw;
            release_q <= accept & ~raw;
            if (tick) begin
                for (int i = 0; i < 16; i++) begin
                    if (raw[i] == stable[i] || accept[i]) begin
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 5'd1;
                    end
                end
            end
        end
    end

`ifdef JOY_AUTOFIRE_EN
    logic [7:0] rate [2];
    logic [1:0] phase;
    logic [1:0] af_active;

    always_comb begin
        af_active = '0;
        fire_out  = '0;
        for (int p = 0; p < 2; p++) begin
            af_active[p] = stable[p*8 + 4] & bus.autofire_sel[p];
            fire_out[p]  = af_active[p] ? phase[p] : stable[p*8 + 4];
        end
    end

    // A freshly accepted fire1 press restarts the square wave high.
    always_ff @(posedge clk or negedge clock_locked) begin
        if (!clock_locked) begin
            phase <= '0;
            for (int p = 0; p < 2; p++) begin
                rate[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (accept[p*8 + 4] && raw[p*8 + 4]) begin
                    phase[p] <= 1'b1;
                    rate[p]  <= '0;
                end else if (!af_active[p]) begin
                    phase[p] <= 1'b0;
                    rate[p]  <= '0;
                end else if (tick) begin
                    if (rate[p] == 8'(AUTOFIRE_TICKS - 1)) begin
                        phase[p] <= ~phase[p];
                        rate[p]  <= '0;
                    end else begin
                        rate[p]  <= rate[p] + 8'd1;
                    end
                end
            end
        end
    end
`else
    logic unused_autofire_sel;
    assign unused_autofire_sel = ^bus.autofire_sel;
    assign fire_out = {stable[12], stable[4]};
`endif

    assign bus.joy1_db     = {stable[7:5],  fire_out[0], stable[3:0]};
    assign bus.joy2_db     = {stable[15:13], fire_out[1], stable[11:8]};
    assign bus.joy_press   = press_q;
    assign bus.joy_release = release_q;
    assign bus.tick        = tick;

endmodule
